// File: rtl/axi4_stream_util_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_stream_util_pkg
// Description : Shared AXI4-Stream helpers: head-cut FSM state type, tkeep
//               byte counter and contiguous-ones keep mask generator.
//               Helpers work on MAX_BYTES-wide vectors; callers size-cast.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_stream_util_pkg;

  // Widest tkeep the helpers accept (512-bit tdata).
  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } head_cut_state_t;

  // Number of valid bytes: position of the leftmost set keep bit plus one.
  function automatic logic [7:0] byte_cnt(input logic [MAX_BYTES-1:0] keep);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) cnt = 8'(i + 1);
    end
    return cnt;
  endfunction

  // n ones starting at bit 0.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input logic [7:0] n);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_stream_byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : axi4_stream_byte_merge
// Description : Combinational byte re-packer for the head-cut stage.
//               mrg_* : residue bytes in [res_cnt-1:0], beat bytes above.
//               shr_* : beat shifted down by cut bytes (next residue, or a
//                       single-beat packet's output word).
//               Bytes outside the resulting tkeep are forced to zero.
// Ports       : res_data_i/res_strb_i/res_cnt_i  residue word, strobes, count
//               beat_data_i/beat_keep_i/beat_strb_i current input beat
//               cut_i                             bytes removed from the head
//               mrg_*_o, shr_*_o                  merged / shifted results
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_stream_byte_merge
  import axi4_stream_util_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic [DATA_WIDTH-1:0]     res_data_i,
  input  logic [DATA_WIDTH_B-1:0]   res_strb_i,
  input  logic [DATA_WIDTH_B_W:0]   res_cnt_i,
  input  logic [DATA_WIDTH-1:0]     beat_data_i,
  input  logic [DATA_WIDTH_B-1:0]   beat_keep_i,
  input  logic [DATA_WIDTH_B-1:0]   beat_strb_i,
  input  logic [DATA_WIDTH_B_W-1:0] cut_i,
  output logic [DATA_WIDTH-1:0]     mrg_data_o,
  output logic [DATA_WIDTH_B-1:0]   mrg_keep_o,
  output logic [DATA_WIDTH_B-1:0]   mrg_strb_o,
  output logic [DATA_WIDTH-1:0]     shr_data_o,
  output logic [DATA_WIDTH_B-1:0]   shr_keep_o,
  output logic [DATA_WIDTH_B-1:0]   shr_strb_o
);

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [DATA_WIDTH_B-1:0] k);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < DATA_WIDTH_B; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  logic [DATA_WIDTH_B-1:0] w_res_keep;
  logic [DATA_WIDTH-1:0]   w_mrg_data_raw;
  logic [DATA_WIDTH-1:0]   w_shr_data_raw;

  // Residue bytes are always valid; their count alone defines their keep.
  assign w_res_keep     = DATA_WIDTH_B'(keep_mask(8'(res_cnt_i)));

  // A shift by the full width (res_cnt = W, i.e. no residue room) yields zero.
  assign w_mrg_data_raw = res_data_i | (beat_data_i << {res_cnt_i, 3'b000});
  assign mrg_keep_o     = w_res_keep | (beat_keep_i << res_cnt_i);
  assign mrg_data_o     = w_mrg_data_raw & byte_mask(mrg_keep_o);
  assign mrg_strb_o     = (res_strb_i | (beat_strb_i << res_cnt_i)) & mrg_keep_o;

  assign w_shr_data_raw = beat_data_i >> {cut_i, 3'b000};
  assign shr_keep_o     = beat_keep_i >> cut_i;
  assign shr_data_o     = w_shr_data_raw & byte_mask(shr_keep_o);
  assign shr_strb_o     = (beat_strb_i >> cut_i) & shr_keep_o;

endmodule
`default_nettype wire

// File: rtl/axi4_stream_head_cut.sv
`default_nettype none
// ============================================================================
// Module      : axi4_stream_head_cut
// Description : Removes the first cut_i bytes of every AXI4-Stream packet and
//               re-packs the remainder LSB-aligned. Output words are full
//               except the last. Output stage is fully registered.
// Ports       : clk_i, rst_i (sync, active-high)
//               cut_i        bytes to strip, sampled on the first beat
//               pkt_i_*      input stream (slave)
//               pkt_o_*      output stream (master)
//               hdr_o, hdr_valid_o  removed header bytes + pulse, only when
//                            AXI4_STREAM_HEAD_CUT_HDR_OUT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_stream_head_cut
  import axi4_stream_util_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH_B_W-1:0] cut_i,
  input  logic                      pkt_i_tvalid,
  output logic                      pkt_i_tready,
  input  logic [DATA_WIDTH-1:0]     pkt_i_tdata,
  input  logic [DATA_WIDTH_B-1:0]   pkt_i_tkeep,
  input  logic [DATA_WIDTH_B-1:0]   pkt_i_tstrb,
  input  logic                      pkt_i_tlast,
  input  logic [ID_WIDTH-1:0]       pkt_i_tid,
  input  logic [DEST_WIDTH-1:0]     pkt_i_tdest,
  input  logic [USER_WIDTH-1:0]     pkt_i_tuser,
  output logic                      pkt_o_tvalid,
  input  logic                      pkt_o_tready,
  output logic [DATA_WIDTH-1:0]     pkt_o_tdata,
  output logic [DATA_WIDTH_B-1:0]   pkt_o_tkeep,
  output logic [DATA_WIDTH_B-1:0]   pkt_o_tstrb,
  output logic                      pkt_o_tlast,
  output logic [ID_WIDTH-1:0]       pkt_o_tid,
  output logic [DEST_WIDTH-1:0]     pkt_o_tdest,
  output logic [USER_WIDTH-1:0]     pkt_o_tuser
`ifdef AXI4_STREAM_HEAD_CUT_HDR_OUT_EN
  ,
  output logic [DATA_WIDTH-1:0]     hdr_o,
  output logic                      hdr_valid_o
`endif
);

  localparam int CNT_W = DATA_WIDTH_B_W + 1;  // byte count 0..W
  localparam int SUM_W = DATA_WIDTH_B_W + 2;  // residue + beat, up to 2W-1

  head_cut_state_t r_state, w_state_nxt;

  logic [DATA_WIDTH_B_W-1:0] r_cut, w_cut_eff;
  logic [ID_WIDTH-1:0]       r_tid;
  logic [DEST_WIDTH-1:0]     r_tdest;
  logic [USER_WIDTH-1:0]     r_tuser;

  logic [DATA_WIDTH-1:0]     r_res_data;
  logic [DATA_WIDTH_B-1:0]   r_res_strb;
  logic [CNT_W-1:0]          r_res_cnt;

  logic                      r_o_valid, r_o_last;
  logic [DATA_WIDTH-1:0]     r_o_data;
  logic [DATA_WIDTH_B-1:0]   r_o_keep, r_o_strb;
  logic [ID_WIDTH-1:0]       r_o_tid;
  logic [DEST_WIDTH-1:0]     r_o_tdest;
  logic [USER_WIDTH-1:0]     r_o_tuser;

  logic                      w_slot_free, w_acc;
  logic [CNT_W-1:0]          w_in_cnt;
  logic [SUM_W-1:0]          w_sum;
  logic [DATA_WIDTH_B-1:0]   w_flush_keep;

  logic [DATA_WIDTH-1:0]     w_mrg_data, w_shr_data;
  logic [DATA_WIDTH_B-1:0]   w_mrg_keep, w_mrg_strb, w_shr_keep, w_shr_strb;

  logic                      w_emit, w_e_last, w_res_ld, w_first_ld;
  logic [DATA_WIDTH-1:0]     w_e_data;
  logic [DATA_WIDTH_B-1:0]   w_e_keep, w_e_strb;

  assign w_slot_free  = !r_o_valid || pkt_o_tready;
  assign pkt_i_tready = (r_state != FLUSH) && w_slot_free;
  assign w_acc        = pkt_i_tvalid && pkt_i_tready;

  // The first beat is processed with the live cut_i; later beats use the latch.
  assign w_cut_eff    = (r_state == FIRST) ? cut_i : r_cut;
  assign w_in_cnt     = CNT_W'(byte_cnt(MAX_BYTES'(pkt_i_tkeep)));
  assign w_sum        = SUM_W'(r_res_cnt) + SUM_W'(w_in_cnt);
  assign w_flush_keep = DATA_WIDTH_B'(keep_mask(8'(r_res_cnt)));

  axi4_stream_byte_merge #(
    .DATA_WIDTH     (DATA_WIDTH),
    .DATA_WIDTH_B   (DATA_WIDTH_B),
    .DATA_WIDTH_B_W (DATA_WIDTH_B_W)
  ) u_merge (
    .res_data_i  (r_res_data),
    .res_strb_i  (r_res_strb),
    .res_cnt_i   (r_res_cnt),
    .beat_data_i (pkt_i_tdata),
    .beat_keep_i (pkt_i_tkeep),
    .beat_strb_i (pkt_i_tstrb),
    .cut_i       (w_cut_eff),
    .mrg_data_o  (w_mrg_data),
    .mrg_keep_o  (w_mrg_keep),
    .mrg_strb_o  (w_mrg_strb),
    .shr_data_o  (w_shr_data),
    .shr_keep_o  (w_shr_keep),
    .shr_strb_o  (w_shr_strb)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= FIRST;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_e_data    = w_mrg_data;
    w_e_keep    = w_mrg_keep;
    w_e_strb    = w_mrg_strb;
    w_e_last    = 1'b0;
    w_res_ld    = 1'b0;
    w_first_ld  = 1'b0;
    case (r_state)
      FIRST: begin
        if (w_acc) begin
          w_first_ld = 1'b1;
          if (cut_i == '0) begin
            // Nothing to strip: forward the beat as-is, one cycle later.
            w_emit   = 1'b1;
            w_e_data = pkt_i_tdata;
            w_e_keep = pkt_i_tkeep;
            w_e_strb = pkt_i_tstrb;
            w_e_last = pkt_i_tlast;
            if (!pkt_i_tlast) w_state_nxt = BODY;
          end else if (!pkt_i_tlast) begin
            w_res_ld    = 1'b1;
            w_state_nxt = BODY;
          end else if (w_in_cnt > CNT_W'(cut_i)) begin
            w_emit   = 1'b1;
            w_e_data = w_shr_data;
            w_e_keep = w_shr_keep;
            w_e_strb = w_shr_strb;
            w_e_last = 1'b1;
          end
          // Otherwise the whole single-beat packet is header: dropped.
        end
      end
      BODY: begin
        if (w_acc) begin
          w_emit = 1'b1;
          if (r_cut == '0) begin
            w_e_data = pkt_i_tdata;
            w_e_keep = pkt_i_tkeep;
            w_e_strb = pkt_i_tstrb;
            w_e_last = pkt_i_tlast;
            if (pkt_i_tlast) w_state_nxt = FIRST;
          end else if (!pkt_i_tlast) begin
            w_res_ld = 1'b1;
          end else if (w_sum <= SUM_W'(DATA_WIDTH_B)) begin
            w_e_last    = 1'b1;
            w_state_nxt = FIRST;
          end else begin
            // Tail overflows this word: emit it full, hold the rest for FLUSH.
            w_res_ld    = 1'b1;
            w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (w_slot_free) begin
          w_emit      = 1'b1;
          w_e_data    = r_res_data;
          w_e_keep    = w_flush_keep;
          w_e_strb    = r_res_strb;
          w_e_last    = 1'b1;
          w_state_nxt = FIRST;
        end
      end
      default: w_state_nxt = FIRST;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res_data <= '0;
      r_res_strb <= '0;
      r_res_cnt  <= '0;
      r_cut      <= '0;
      r_tid      <= '0;
      r_tdest    <= '0;
      r_tuser    <= '0;
    end else begin
      if (w_res_ld) begin
        r_res_data <= w_shr_data;
        r_res_strb <= w_shr_strb;
        r_res_cnt  <= w_in_cnt - CNT_W'(w_cut_eff);
      end
      if (w_first_ld) begin
        r_cut   <= cut_i;
        r_tid   <= pkt_i_tid;
        r_tdest <= pkt_i_tdest;
        r_tuser <= pkt_i_tuser;
      end
    end
  end

  // Output slot: loads only when empty or draining this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_keep  <= '0;
      r_o_strb  <= '0;
      r_o_last  <= 1'b0;
      r_o_tid   <= '0;
      r_o_tdest <= '0;
      r_o_tuser <= '0;
    end else if (w_slot_free) begin
      r_o_valid <= w_emit;
      if (w_emit) begin
        r_o_data  <= w_e_data;
        r_o_keep  <= w_e_keep;
        r_o_strb  <= w_e_strb;
        r_o_last  <= w_e_last;
        r_o_tid   <= (r_state == FIRST) ? pkt_i_tid   : r_tid;
        r_o_tdest <= (r_state == FIRST) ? pkt_i_tdest : r_tdest;
        r_o_tuser <= (r_state == FIRST) ? pkt_i_tuser : r_tuser;
      end
    end
  end

  assign pkt_o_tvalid = r_o_valid;
  assign pkt_o_tdata  = r_o_data;
  assign pkt_o_tkeep  = r_o_keep;
  assign pkt_o_tstrb  = r_o_strb;
  assign pkt_o_tlast  = r_o_last;
  assign pkt_o_tid    = r_o_tid;
  assign pkt_o_tdest  = r_o_tdest;
  assign pkt_o_tuser  = r_o_tuser;

`ifdef AXI4_STREAM_HEAD_CUT_HDR_OUT_EN
  logic [DATA_WIDTH-1:0] r_hdr, w_hdr_mask;
  logic                  r_hdr_valid;

  always_comb begin
    w_hdr_mask = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      w_hdr_mask[8*i +: 8] = {8{(i < int'(cut_i))}};
    end
  end

  // Pulses for every first beat with a non-zero cut, dropped packets included.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hdr       <= '0;
      r_hdr_valid <= 1'b0;
    end else begin
      r_hdr_valid <= w_acc && (r_state == FIRST) && (cut_i != '0);
      if (w_acc && (r_state == FIRST) && (cut_i != '0)) begin
        r_hdr <= pkt_i_tdata & w_hdr_mask;
      end
    end
  end

  assign hdr_o       = r_hdr;
  assign hdr_valid_o = r_hdr_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_stream_head_cut.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_stream_head_cut
// Description : Self-checking bench for axi4_stream_head_cut (DATA_WIDTH=32).
//               Packets are byte lists; the reference drops the first cut
//               bytes and chunks the rest into 4-byte words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_stream_head_cut;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [W-1:0]  keep;
    logic [W-1:0]  strb;
    logic          last;
    logic          id;
    logic          dest;
    logic          user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cut;
  logic          i_valid, i_ready, i_last, i_id, i_dest, i_user;
  logic [DW-1:0] i_data;
  logic [W-1:0]  i_keep, i_strb;
  logic          o_valid, o_ready, o_last, o_id, o_dest, o_user;
  logic [DW-1:0] o_data;
  logic [W-1:0]  o_keep, o_strb;
`ifdef AXI4_STREAM_HEAD_CUT_HDR_OUT_EN
  logic [DW-1:0] hdr;
  logic          hdr_valid;
`endif

  always #5 clk = ~clk;

  axi4_stream_head_cut #(.DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cut_i        (cut),
    .pkt_i_tvalid (i_valid),
    .pkt_i_tready (i_ready),
    .pkt_i_tdata  (i_data),
    .pkt_i_tkeep  (i_keep),
    .pkt_i_tstrb  (i_strb),
    .pkt_i_tlast  (i_last),
    .pkt_i_tid    (i_id),
    .pkt_i_tdest  (i_dest),
    .pkt_i_tuser  (i_user),
    .pkt_o_tvalid (o_valid),
    .pkt_o_tready (o_ready),
    .pkt_o_tdata  (o_data),
    .pkt_o_tkeep  (o_keep),
    .pkt_o_tstrb  (o_strb),
    .pkt_o_tlast  (o_last),
    .pkt_o_tid    (o_id),
    .pkt_o_tdest  (o_dest),
    .pkt_o_tuser  (o_user)
`ifdef AXI4_STREAM_HEAD_CUT_HDR_OUT_EN
    ,
    .hdr_o        (hdr),
    .hdr_valid_o  (hdr_valid)
`endif
  );

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;   // 0 random, 1 always ready, 2 never ready
  bit    lat_chk = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sink ready pattern.
  initial begin
    o_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       o_ready = ($urandom_range(0, 3) != 0);
        1:       o_ready = 1'b1;
        default: o_ready = 1'b0;
      endcase
    end
  end

  // Output monitor / scoreboard, sampled mid-cycle.
  initial begin
    beat_t         obs, exp;
    bit            acc_prev;
    logic [DW+2*W:0] in_prev;
    acc_prev = 1'b0;
    in_prev  = '0;
    forever begin
      @(negedge clk);
      if (!rst && o_valid && o_ready) begin
        obs = {o_data, o_keep, o_strb, o_last, o_id, o_dest, o_user};
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          exp = exp_q.pop_front();
          check("out_beat", 64'(obs), 64'(exp));
        end
      end
      if (lat_chk && acc_prev) begin
        check("pass_latency", 64'({o_valid, o_data, o_keep, o_strb, o_last}),
              64'({1'b1, in_prev}));
      end
      acc_prev = !rst && i_valid && i_ready;
      in_prev  = {i_data, i_keep, i_strb, i_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic [W-1:0] s,
                            input logic l, input logic id, input logic dest, input logic user,
                            input logic [CW-1:0] c);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    i_valid = 1'b1;
    i_data = d; i_keep = k; i_strb = s; i_last = l;
    i_id = id; i_dest = dest; i_user = user; cut = c;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = i_ready;
      tick();
      n++;
    end
    if (!acc) check("input_timeout", 64'(acc), 64'd1);
    i_valid = 1'b0;
  endtask

  // Builds a packet, queues the expected output words, then drives it.
  task automatic send_pkt(input int len, input int c, input logic id0, input logic dest0,
                          input logic user0, input bit seq, input bit gaps);
    byte unsigned  pb[$];
    bit            ps[$];
    int            olen, k, nb;
    beat_t         e;
    logic [DW-1:0] d;
    logic [W-1:0]  kp, sp;
    for (int i = 0; i < len; i++) begin
      pb.push_back(seq ? 8'(i) : 8'($urandom));
      ps.push_back(1'($urandom));
    end
    olen = len - c;
    k    = 0;
    while (k < olen) begin
      e = '0;
      for (int j = 0; j < W && k < olen; j++) begin
        e.data[8*j +: 8] = pb[c+k];
        e.keep[j]        = 1'b1;
        e.strb[j]        = ps[c+k];
        k++;
      end
      e.last = (k == olen);
      e.id = id0; e.dest = dest0; e.user = user0;
      exp_q.push_back(e);
    end
    nb = (len + W - 1) / W;
    for (int b = 0; b < nb; b++) begin
      d = '0; kp = '0; sp = '0;
      for (int j = 0; j < W; j++) begin
        if (b*W + j < len) begin
          d[8*j +: 8] = pb[b*W+j];
          kp[j]       = 1'b1;
          sp[j]       = ps[b*W+j];
        end
      end
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      // Later beats carry random sideband and cut values, which must be ignored.
      drive_beat(d, kp, sp, (b == nb-1),
                 (b == 0) ? id0 : 1'($urandom), (b == 0) ? dest0 : 1'($urandom),
                 (b == 0) ? user0 : 1'($urandom), (b == 0) ? CW'(c) : CW'($urandom));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cut = '0; i_valid = 1'b0; i_data = '0; i_keep = '0; i_strb = '0;
    i_last = 1'b0; i_id = 1'b0; i_dest = 1'b0; i_user = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", 64'(o_valid), 64'd0);
    check("rst_tdata",  64'(o_data),  64'd0);
    check("rst_tkeep",  64'(o_keep),  64'd0);
    check("rst_tstrb",  64'(o_strb),  64'd0);
    check("rst_tlast",  64'(o_last),  64'd0);
    check("rst_tready", 64'(i_ready), 64'd1);
    tick();

    // cut=1, 12-byte packet in 3 beats, random sink.
    ready_mode = 0;
    send_pkt(12, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();

    // cut=1, 8-byte packet, sink always ready: one FLUSH cycle with tready low.
    ready_mode = 1;
    repeat (2) tick();
    send_pkt(8, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush_tready_low", 64'(i_ready), 64'd0);
    tick();
    check("flush_tready_back", 64'(i_ready), 64'd1);
    drain();

    // cut=3, 5-byte packet -> single 2-byte word.
    ready_mode = 0;
    send_pkt(5, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    // Fully-cut single beat is dropped; following cut=0 packet keeps its own sideband.
    send_pkt(2, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_pkt(6, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // cut=0 back-to-back, full rate, one-cycle latency.
    ready_mode = 1;
    repeat (2) tick();
    lat_chk = 1'b1;
    send_pkt(8, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_pkt(5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(12, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    lat_chk = 1'b0;

    // Reset while held in FLUSH.
    ready_mode = 2;
    repeat (2) tick();
    send_pkt(8, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_hold_tready", 64'(i_ready), 64'd0);
    check("flush_hold_tvalid", 64'(o_valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_tvalid", 64'(o_valid), 64'd0);
    check("midrst_tready", 64'(i_ready), 64'd1);
    tick();
    ready_mode = 0;
    send_pkt(9, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();

    // Random packets, lengths and cuts.
    for (int p = 0; p < 40; p++) begin
      send_pkt($urandom_range(1, 16), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               1'($urandom), 1'b0, 1'b1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
